// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer behind the last FFT butterfly column: a frame is
// written in natural order and read back in bit-reversed index order.
module fft_bitrev_reorder #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              overflow
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);

  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_sel;
  logic              rd_sel;
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  rd_cnt;
  logic              wr_acc;
  logic              rd_xfer;
  logic              wr_done;
  logic              rd_done;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready  = !full[wr_sel];
  assign wr_acc    = in_valid && in_ready;
  assign out_valid = full[rd_sel];
  assign rd_xfer   = out_valid && out_ready;
  assign wr_done   = wr_acc && (wr_cnt == CNT_MAX);
  assign rd_done   = rd_xfer && (rd_cnt == CNT_MAX);
  assign out_data  = mem[rd_sel][bitrev(rd_cnt)];
  assign out_last  = out_valid && (rd_cnt == CNT_MAX);

  // Writer and reader can never target the same bank in one cycle, so the
  // set and clear below are independent.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_sel] = 1'b1;
    if (rd_done) full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_acc) wr_cnt <= wr_cnt + LOG2N'(1);
      if (wr_done) wr_sel <= !wr_sel;
      if (rd_xfer) rd_cnt <= rd_cnt + LOG2N'(1);
      if (rd_done) rd_sel <= !rd_sel;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Bank contents are deliberately left out of reset; the full flags gate them.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_sel][wr_cnt] <= in_data;
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: main instance with LOG2N=3 plus
// LOG2N=1 and LOG2N=4 instances for the frame-length corner cases.
module tb_fft_bitrev_reorder;

  typedef struct {
    logic [63:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        overflow;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, overflow1;
  logic [15:0] in_data1, out_data1;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4, overflow4;
  logic [15:0] in_data4, out_data4;

  int   tests  = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.LOG2N(3), .DATA_W(64)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow));

  fft_bitrev_reorder #(.LOG2N(1), .DATA_W(16)) dut1 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1), .overflow(overflow1));

  fft_bitrev_reorder #(.LOG2N(4), .DATA_W(16)) dut4 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_last(out_last4), .overflow(overflow4));

  function automatic int rev_bits(input int x, input int nbits);
    int r = 0;
    for (int k = 0; k < nbits; k++) r = r * 2 + ((x >> k) & 1);
    return r;
  endfunction

  // Expected output order for one 8-word frame whose natural-order words are base..base+7.
  task automatic push_frame(input int base);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.d    = 64'(base + rev_bits(i, 3));
      e.last = (i == 7);
      sb.push_back(e);
    end
  endtask

  task automatic drive_word(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: every presented word must equal the queue head; a
  // transfer pops it. Stalled cycles therefore also check that out_data holds.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        if (out_ready) begin
          tests++; failed++;
          $display("FAIL unexpected_word: got %0h, required no output", out_data);
        end
      end else begin
        tests++;
        if (out_data !== sb[0].d || out_last !== sb[0].last) begin
          failed++;
          $display("FAIL out_word: got data=%0h last=%b, required data=%0h last=%b",
                   out_data, out_last, sb[0].d, sb[0].last);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_state: got v=%b l=%b ovf=%b rdy=%b, required 0 0 0 1",
               out_valid, out_last, overflow, in_ready);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    out_ready = 1'b1;
    push_frame(0);
    for (int i = 0; i < 8; i++) begin
      drive_word(64'(i));
      tests++;
      if (out_valid !== (i == 7)) begin
        failed++;
        $display("FAIL latency_word%0d: got out_valid=%b, required %b", i, out_valid, i == 7);
      end
    end
    wait_drain(ok);
    tests++;
    if (!ok || out_valid !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL single_drain: got done=%b v=%b ovf=%b, required 1 0 0", ok, out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b1;
    push_frame(0); push_frame(8); push_frame(16);
    for (int i = 0; i < 24; i++) begin
      tests++;
      if (in_ready !== 1'b1) begin
        failed++;
        $display("FAIL b2b_in_ready word%0d: got %b, required 1", i, in_ready);
      end
      drive_word(64'(i));
    end
    wait_drain(ok);
    tests++;
    if (!ok || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL b2b_drain: got done=%b v=%b, required 1 0", ok, out_valid);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    out_ready = 1'b0;
    push_frame(0); push_frame(8);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (in_ready !== 1'b1) begin
        failed++;
        $display("FAIL ovf_in_ready word%0d: got %b, required 1", i, in_ready);
      end
      drive_word(64'(i));
    end
    tests++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL ovf_stall: got rdy=%b ovf=%b, required 0 0", in_ready, overflow);
    end
    drive_word(64'd99);
    tests++;
    if (overflow !== 1'b1) begin
      failed++;
      $display("FAIL ovf_flag: got %b, required 1", overflow);
    end
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_drain(ok);
    tests++;
    if (!ok || out_valid !== 1'b0 || overflow !== 1'b1 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL ovf_drain: got done=%b v=%b ovf=%b rdy=%b, required 1 0 1 1",
               ok, out_valid, overflow, in_ready);
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    int n;
    out_ready = 1'b0;
    push_frame(32);
    for (int i = 0; i < 8; i++) drive_word(64'(32 + i));
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      out_ready = (n % 2 == 0);
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    ok = (sb.size() == 0);
    tests++;
    if (!ok || out_valid !== 1'b0 || n != 15) begin
      failed++;
      $display("FAIL toggle_drain: got done=%b v=%b cycles=%0d, required 1 0 15", ok, out_valid, n);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) drive_word(64'(200 + i));
    drive_word(64'd250);
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL midreset_state: got v=%b l=%b ovf=%b rdy=%b, required 0 0 0 1",
               out_valid, out_last, overflow, in_ready);
    end
    out_ready = 1'b1;
    push_frame(100);
    for (int i = 0; i < 8; i++) drive_word(64'(100 + i));
    wait_drain(ok);
    tests++;
    if (!ok || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL midreset_drain: got done=%b v=%b, required 1 0", ok, out_valid);
    end
  endtask

  task automatic test_log2n_1();
    logic [15:0] got[$];
    logic        lst[$];
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 16'hA5A5;
    @(posedge clk); #1;
    in_data1 = 16'h5A3C;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid1 && out_ready1) begin
        got.push_back(out_data1);
        lst.push_back(out_last1);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (got.size() != 2) begin
      failed++;
      $display("FAIL n2_count: got %0d words, required 2", got.size());
    end else begin
      tests++;
      if (got[0] !== 16'hA5A5 || got[1] !== 16'h5A3C || lst[0] !== 1'b0 || lst[1] !== 1'b1) begin
        failed++;
        $display("FAIL n2_order: got %h/%b %h/%b, required a5a5/0 5a3c/1",
                 got[0], lst[0], got[1], lst[1]);
      end
    end
  endtask

  task automatic test_log2n_4();
    logic [15:0] got[$];
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid4 = 1'b1; in_data4 = 16'(i);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid4 && out_ready4) got.push_back(out_data4);
    end
    @(posedge clk); #1;
    tests++;
    if (got.size() != 16) begin
      failed++;
      $display("FAIL n16_count: got %0d words, required 16", got.size());
    end else begin
      tests++;
      if (got[1] !== 16'd8 || got[8] !== 16'd1) begin
        failed++;
        $display("FAIL n16_spot: got 2nd=%0d 9th=%0d, required 8 1", got[1], got[8]);
      end
      for (int i = 0; i < 16; i++) begin
        tests++;
        if (got[i] !== 16'(rev_bits(i, 4))) begin
          failed++;
          $display("FAIL n16_word%0d: got %0d, required %0d", i, got[i], rev_bits(i, 4));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    clr_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    mon_en = 1'b1;
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_ready_toggle();
    test_mid_frame_reset();
    test_log2n_1();
    test_log2n_4();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
